// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the two-master single-port RAM arbiter.
package ram_arbiter_pkg;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } ownerT;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } stateT;

  localparam logic [1:0] WE_READ = 2'b00;

  // Burst counter width never drops below three bits, even for tiny bursts.
  function automatic int cntWidth(input int maxBurst);
    cntWidth = ($clog2(maxBurst) < 3) ? 3 : $clog2(maxBurst);
  endfunction

  function automatic logic isRead(input logic [1:0] we);
    isRead = (we == WE_READ);
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Bus bundle between two masters, the arbiter and the RAM port.
interface ram_arbiter_if;

  logic        m0_req;
  logic        m1_req;
  logic        m0_lock;
  logic        m1_lock;
  logic [1:0]  m0_we;
  logic [1:0]  m1_we;
  logic [31:0] m0_addr;
  logic [31:0] m1_addr;
  logic [31:0] m0_wdata;
  logic [31:0] m1_wdata;
  logic        m0_gnt;
  logic        m1_gnt;
  logic [31:0] m0_rdata;
  logic [31:0] m1_rdata;
  logic        m0_rvalid;
  logic        m1_rvalid;
  logic [1:0]  ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  modport slave (
    input  m0_req, m1_req, m0_lock, m1_lock, m0_we, m1_we,
    input  m0_addr, m1_addr, m0_wdata, m1_wdata, ram_rdata,
    output m0_gnt, m1_gnt, m0_rdata, m1_rdata, m0_rvalid, m1_rvalid,
    output ram_we, ram_addr, ram_wdata
  );

  modport master (
    output m0_req, m1_req, m0_lock, m1_lock, m0_we, m1_we,
    output m0_addr, m1_addr, m0_wdata, m1_wdata, ram_rdata,
    input  m0_gnt, m1_gnt, m0_rdata, m1_rdata, m0_rvalid, m1_rvalid,
    input  ram_we, ram_addr, ram_wdata
  );

endinterface

// File: rtl/ram_arbiter.sv
// Two-master RAM arbiter: tie-break on last owner, lockable bursts capped at MAX_BURST
// beats when the other master is waiting, registered read return.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 8
) (
  input logic          clk,
  input logic          reset,
  ram_arbiter_if.slave bus
);

  localparam int              CW        = cntWidth(MAX_BURST);
  localparam logic [CW-1:0]   LAST_BEAT = CW'(MAX_BURST - 1);
  localparam logic [CW-1:0]   CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0]   CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};

  stateT          stateR;
  stateT          nextStateS;
  ownerT          lastOwnerR;
  logic [CW-1:0]  beatCntR;
  logic [CW-1:0]  nextBeatCntS;

  logic           gnt0S;
  logic           gnt1S;
  logic           beat0S;
  logic           beat1S;

  logic [1:0]     ramWeS;
  logic [31:0]    ramAddrS;
  logic [31:0]    ramWdataS;

  logic [31:0]    rdata0R;
  logic [31:0]    rdata1R;
  logic           rvalid0R;
  logic           rvalid1R;

  // Grants come straight from the registered state, so they can never overlap.
  assign gnt0S  = (stateR == OWN0);
  assign gnt1S  = (stateR == OWN1);
  assign beat0S = gnt0S && bus.m0_req;
  assign beat1S = gnt1S && bus.m1_req;

  assign bus.m0_gnt    = gnt0S;
  assign bus.m1_gnt    = gnt1S;
  assign bus.m0_rdata  = rdata0R;
  assign bus.m1_rdata  = rdata1R;
  assign bus.m0_rvalid = rvalid0R;
  assign bus.m1_rvalid = rvalid1R;
  assign bus.ram_we    = ramWeS;
  assign bus.ram_addr  = ramAddrS;
  assign bus.ram_wdata = ramWdataS;

  // RAM port mux: only a completing beat drives the port, otherwise it sits at zero.
  always_comb begin
    ramWeS    = WE_READ;
    ramAddrS  = 32'h0000_0000;
    ramWdataS = 32'h0000_0000;
    if (beat0S) begin
      ramWeS    = bus.m0_we;
      ramAddrS  = bus.m0_addr;
      ramWdataS = bus.m0_wdata;
    end else if (beat1S) begin
      ramWeS    = bus.m1_we;
      ramAddrS  = bus.m1_addr;
      ramWdataS = bus.m1_wdata;
    end else begin
      ramWeS    = WE_READ;
      ramAddrS  = 32'h0000_0000;
      ramWdataS = 32'h0000_0000;
    end
  end

  // Arbitration next state and burst counter.
  always_comb begin
    nextStateS   = stateR;
    nextBeatCntS = beatCntR;
    case (stateR)
      IDLE: begin
        if (bus.m0_req && !bus.m1_req) begin
          nextStateS = OWN0;
        end else if (bus.m1_req && !bus.m0_req) begin
          nextStateS = OWN1;
        end else if (bus.m0_req && bus.m1_req) begin
          nextStateS = (lastOwnerR == M1) ? OWN0 : OWN1;
        end else begin
          nextStateS = IDLE;
        end
      end
      OWN0: begin
        if (beat0S && bus.m0_lock) begin
          nextStateS = ((beatCntR == LAST_BEAT) && bus.m1_req) ? OWN1 : OWN0;
        end else if (bus.m1_req) begin
          nextStateS = OWN1;
        end else if (bus.m0_req) begin
          nextStateS = OWN0;
        end else begin
          nextStateS = IDLE;
        end
      end
      OWN1: begin
        if (beat1S && bus.m1_lock) begin
          nextStateS = ((beatCntR == LAST_BEAT) && bus.m0_req) ? OWN0 : OWN1;
        end else if (bus.m0_req) begin
          nextStateS = OWN0;
        end else if (bus.m1_req) begin
          nextStateS = OWN1;
        end else begin
          nextStateS = IDLE;
        end
      end
      default: begin
        nextStateS = IDLE;
      end
    endcase

    // An uncontested locked burst simply wraps the counter and keeps the bus.
    if ((nextStateS != stateR) || (nextStateS == IDLE)) begin
      nextBeatCntS = CNT_ZERO;
    end else if (beat0S || beat1S) begin
      nextBeatCntS = (beatCntR == LAST_BEAT) ? CNT_ZERO : (beatCntR + CNT_ONE);
    end else begin
      nextBeatCntS = beatCntR;
    end
  end

  // Arbitration state, burst counter and tie-break history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateR     <= IDLE;
      beatCntR   <= CNT_ZERO;
      lastOwnerR <= M1;
    end else begin
      stateR   <= nextStateS;
      beatCntR <= nextBeatCntS;
      if (beat0S) begin
        lastOwnerR <= M0;
      end else if (beat1S) begin
        lastOwnerR <= M1;
      end else begin
        lastOwnerR <= lastOwnerR;
      end
    end
  end

  // Read return: capture RAM data on a read beat and pulse rvalid for one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata0R  <= 32'h0000_0000;
      rdata1R  <= 32'h0000_0000;
      rvalid0R <= 1'b0;
      rvalid1R <= 1'b0;
    end else begin
      rvalid0R <= beat0S && isRead(bus.m0_we);
      rvalid1R <= beat1S && isRead(bus.m1_we);
      if (beat0S && isRead(bus.m0_we)) begin
        rdata0R <= bus.ram_rdata;
      end else begin
        rdata0R <= rdata0R;
      end
      if (beat1S && isRead(bus.m1_we)) begin
        rdata1R <= bus.ram_rdata;
      end else begin
        rdata1R <= rdata1R;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus a read-data scoreboard.
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   passCnt  = 0;
  int   totalCnt = 0;

  logic [31:0] mem [0:255];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  logic [31:0] expData;

  always #5 clk = ~clk;

  ram_arbiter_if bus ();

  ram_arbiter #(.MAX_BURST(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Combinational RAM model; writes land at the clock edge of the beat.
  assign bus.ram_rdata = mem[bus.ram_addr[7:0]];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
    mem[8'h10] = 32'hDEAD_BEEF;
    forever begin
      @(posedge clk);
      if (bus.ram_we != 2'b00) mem[bus.ram_addr[7:0]] <= bus.ram_wdata;
    end
  end

  function automatic logic [31:0] expRam(input logic [7:0] a);
    return 32'hC0DE_0000 | {24'h000000, a};
  endfunction

  // Scoreboard: every rvalid pops the oldest expected word for that master.
  always @(negedge clk) begin
    if (bus.m0_rvalid) begin
      totalCnt++;
      if (q0.size() == 0) $display("FAIL m0_unexpected_rvalid: got rdata %h, expected no rvalid", bus.m0_rdata);
      else begin
        expData = q0.pop_front();
        if (bus.m0_rdata !== expData) $display("FAIL m0_rdata: got %h, expected %h", bus.m0_rdata, expData);
        else passCnt++;
      end
    end
    if (bus.m1_rvalid) begin
      totalCnt++;
      if (q1.size() == 0) $display("FAIL m1_unexpected_rvalid: got rdata %h, expected no rvalid", bus.m1_rdata);
      else begin
        expData = q1.pop_front();
        if (bus.m1_rdata !== expData) $display("FAIL m1_rdata: got %h, expected %h", bus.m1_rdata, expData);
        else passCnt++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    bus.m0_req = 1'b0;  bus.m1_req = 1'b0;
    bus.m0_lock = 1'b0; bus.m1_lock = 1'b0;
    bus.m0_we = 2'b00;  bus.m1_we = 2'b00;
    bus.m0_addr = 32'h0; bus.m1_addr = 32'h0;
    bus.m0_wdata = 32'h0; bus.m1_wdata = 32'h0;
  endtask

  task automatic resetDut();
    clearInputs();
    step();
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    totalCnt++; if ({bus.m0_gnt, bus.m1_gnt} !== 2'b00) $display("FAIL reset_gnt: got %b, expected %b", {bus.m0_gnt, bus.m1_gnt}, 2'b00); else passCnt++;
    totalCnt++; if ({bus.m0_rvalid, bus.m1_rvalid} !== 2'b00) $display("FAIL reset_rvalid: got %b, expected %b", {bus.m0_rvalid, bus.m1_rvalid}, 2'b00); else passCnt++;
    totalCnt++; if (bus.m0_rdata !== 32'h0) $display("FAIL reset_m0_rdata: got %h, expected %h", bus.m0_rdata, 32'h0); else passCnt++;
    totalCnt++; if (bus.m1_rdata !== 32'h0) $display("FAIL reset_m1_rdata: got %h, expected %h", bus.m1_rdata, 32'h0); else passCnt++;
    totalCnt++; if ({bus.ram_we, bus.ram_addr} !== 34'h0) $display("FAIL reset_ram_port: got %h, expected %h", {bus.ram_we, bus.ram_addr}, 34'h0); else passCnt++;
    step();
    reset = 1'b1;
    @(negedge clk);
    totalCnt++; if ({bus.m0_gnt, bus.m1_gnt} !== 2'b00) $display("FAIL idle_after_reset_gnt: got %b, expected %b", {bus.m0_gnt, bus.m1_gnt}, 2'b00); else passCnt++;
    step();
  endtask

  task automatic test_single_read();
    bus.m0_req = 1'b1; bus.m0_we = 2'b00; bus.m0_addr = 32'h10;
    @(negedge clk);
    totalCnt++; if ({bus.m0_gnt, bus.m1_gnt} !== 2'b00) $display("FAIL single_no_gnt_yet: got %b, expected %b", {bus.m0_gnt, bus.m1_gnt}, 2'b00); else passCnt++;
    step();
    @(negedge clk);
    totalCnt++; if ({bus.m0_gnt, bus.m1_gnt} !== 2'b10) $display("FAIL single_gnt: got %b, expected %b", {bus.m0_gnt, bus.m1_gnt}, 2'b10); else passCnt++;
    totalCnt++; if (bus.ram_addr !== 32'h10) $display("FAIL single_ram_addr: got %h, expected %h", bus.ram_addr, 32'h10); else passCnt++;
    totalCnt++; if (bus.m0_rvalid !== 1'b0) $display("FAIL single_early_rvalid: got %b, expected %b", bus.m0_rvalid, 1'b0); else passCnt++;
    q0.push_back(32'hDEAD_BEEF);
    step();
    bus.m0_req = 1'b0;
    @(negedge clk);
    totalCnt++; if (bus.m0_rvalid !== 1'b1) $display("FAIL single_rvalid: got %b, expected %b", bus.m0_rvalid, 1'b1); else passCnt++;
    totalCnt++; if (bus.m0_rdata !== 32'hDEAD_BEEF) $display("FAIL single_rdata: got %h, expected %h", bus.m0_rdata, 32'hDEAD_BEEF); else passCnt++;
    totalCnt++; if ({bus.m0_gnt, bus.ram_we, bus.ram_addr} !== {1'b1, 34'h0}) $display("FAIL owner_noreq_port: got %h, expected %h", {bus.m0_gnt, bus.ram_we, bus.ram_addr}, {1'b1, 34'h0}); else passCnt++;
    step();
    @(negedge clk);
    totalCnt++; if ({bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid} !== 3'b000) $display("FAIL single_idle: got %b, expected %b", {bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid}, 3'b000); else passCnt++;
    totalCnt++; if (bus.m0_rdata !== 32'hDEAD_BEEF) $display("FAIL single_rdata_hold: got %h, expected %h", bus.m0_rdata, 32'hDEAD_BEEF); else passCnt++;
    step();
  endtask

  task automatic test_alternate();
    resetDut();
    bus.m0_req = 1'b1; bus.m0_addr = 32'h01;
    bus.m1_req = 1'b1; bus.m1_addr = 32'h02;
    step();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      totalCnt++;
      if ({bus.m0_gnt, bus.m1_gnt} !== ((k % 2 == 0) ? 2'b10 : 2'b01))
        $display("FAIL alternate_gnt[%0d]: got %b, expected %b", k, {bus.m0_gnt, bus.m1_gnt}, ((k % 2 == 0) ? 2'b10 : 2'b01));
      else passCnt++;
      if (k % 2 == 0) q0.push_back(expRam(8'h01));
      else q1.push_back(expRam(8'h02));
      step();
    end
    clearInputs();
    step(); step(); step();
  endtask

  task automatic test_burst_lock();
    resetDut();
    bus.m0_req = 1'b1; bus.m0_lock = 1'b1; bus.m0_addr = 32'h03;
    bus.m1_req = 1'b1; bus.m1_addr = 32'h04;
    step();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      totalCnt++;
      if ({bus.m0_gnt, bus.m1_gnt} !== 2'b10) $display("FAIL burst_m0_beat[%0d]: got %b, expected %b", k, {bus.m0_gnt, bus.m1_gnt}, 2'b10);
      else passCnt++;
      q0.push_back(expRam(8'h03));
      step();
    end
    @(negedge clk);
    totalCnt++; if ({bus.m0_gnt, bus.m1_gnt} !== 2'b01) $display("FAIL burst_release: got %b, expected %b", {bus.m0_gnt, bus.m1_gnt}, 2'b01); else passCnt++;
    q1.push_back(expRam(8'h04));
    step();
    clearInputs();
    step(); step(); step();
  endtask

  task automatic test_lock_wrap();
    resetDut();
    bus.m0_req = 1'b1; bus.m0_lock = 1'b1; bus.m0_addr = 32'h40;
    step();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      totalCnt++;
      if (bus.m0_gnt !== 1'b1) $display("FAIL wrap_gnt[%0d]: got %b, expected %b", k, bus.m0_gnt, 1'b1);
      else passCnt++;
      if (k > 0) begin
        totalCnt++;
        if (bus.m0_rvalid !== 1'b1) $display("FAIL wrap_rvalid[%0d]: got %b, expected %b", k, bus.m0_rvalid, 1'b1);
        else passCnt++;
      end
      q0.push_back(expRam(8'h40 + 8'(k)));
      step();
      bus.m0_addr = 32'h40 + 32'(k + 1);
    end
    clearInputs();
    step(); step(); step();
  endtask

  task automatic test_write();
    resetDut();
    bus.m1_req = 1'b1; bus.m1_we = 2'b11; bus.m1_addr = 32'h20; bus.m1_wdata = 32'h1234_5678;
    step();
    @(negedge clk);
    totalCnt++; if ({bus.m0_gnt, bus.m1_gnt} !== 2'b01) $display("FAIL write_gnt: got %b, expected %b", {bus.m0_gnt, bus.m1_gnt}, 2'b01); else passCnt++;
    totalCnt++; if (bus.ram_we !== 2'b11) $display("FAIL write_ram_we: got %b, expected %b", bus.ram_we, 2'b11); else passCnt++;
    totalCnt++; if (bus.ram_addr !== 32'h20) $display("FAIL write_ram_addr: got %h, expected %h", bus.ram_addr, 32'h20); else passCnt++;
    totalCnt++; if (bus.ram_wdata !== 32'h1234_5678) $display("FAIL write_ram_wdata: got %h, expected %h", bus.ram_wdata, 32'h1234_5678); else passCnt++;
    step();
    clearInputs();
    @(negedge clk);
    totalCnt++; if (bus.m1_rvalid !== 1'b0) $display("FAIL write_no_rvalid: got %b, expected %b", bus.m1_rvalid, 1'b0); else passCnt++;
    totalCnt++; if (bus.m1_rdata !== 32'h0) $display("FAIL write_rdata_hold: got %h, expected %h", bus.m1_rdata, 32'h0); else passCnt++;
    totalCnt++; if ({bus.ram_we, bus.ram_wdata} !== 34'h0) $display("FAIL write_port_idle: got %h, expected %h", {bus.ram_we, bus.ram_wdata}, 34'h0); else passCnt++;
    step();
    step();
    bus.m1_req = 1'b1; bus.m1_we = 2'b00; bus.m1_addr = 32'h20;
    step();
    @(negedge clk);
    totalCnt++; if (bus.m1_gnt !== 1'b1) $display("FAIL readback_gnt: got %b, expected %b", bus.m1_gnt, 1'b1); else passCnt++;
    q1.push_back(32'h1234_5678);
    step();
    clearInputs();
    step(); step(); step();
  endtask

  task automatic test_reset_mid();
    resetDut();
    bus.m1_req = 1'b1; bus.m1_we = 2'b00; bus.m1_addr = 32'h05;
    step();
    @(negedge clk);
    totalCnt++; if (bus.m1_gnt !== 1'b1) $display("FAIL midreset_pre_gnt: got %b, expected %b", bus.m1_gnt, 1'b1); else passCnt++;
    #1;
    reset = 1'b0;
    #1;
    totalCnt++; if ({bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid} !== 4'b0000) $display("FAIL midreset_async: got %b, expected %b", {bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid}, 4'b0000); else passCnt++;
    clearInputs();
    step();
    step();
    reset = 1'b1;
    @(negedge clk);
    totalCnt++; if ({bus.m0_rvalid, bus.m1_rvalid} !== 2'b00) $display("FAIL midreset_no_rvalid: got %b, expected %b", {bus.m0_rvalid, bus.m1_rvalid}, 2'b00); else passCnt++;
    step();
    bus.m0_req = 1'b1; bus.m0_addr = 32'h06;
    bus.m1_req = 1'b1; bus.m1_addr = 32'h07;
    step();
    @(negedge clk);
    totalCnt++; if ({bus.m0_gnt, bus.m1_gnt} !== 2'b10) $display("FAIL midreset_tie_m0_first: got %b, expected %b", {bus.m0_gnt, bus.m1_gnt}, 2'b10); else passCnt++;
    q0.push_back(expRam(8'h06));
    step();
    clearInputs();
    step(); step(); step();
  endtask

  initial begin
    reset = 1'b1;
    clearInputs();
    #1;
    reset = 1'b0;
    test_reset();
    test_single_read();
    test_alternate();
    test_burst_lock();
    test_lock_wrap();
    test_write();
    test_reset_mid();
    totalCnt++; if (q0.size() !== 0) $display("FAIL m0_missing_rvalid: got %0d pending, expected %0d", q0.size(), 0); else passCnt++;
    totalCnt++; if (q1.size() !== 0) $display("FAIL m1_missing_rvalid: got %0d pending, expected %0d", q1.size(), 0); else passCnt++;
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 8, max consecutive locked beats before forced release when the other master is requesting.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 m0_req, m1_req  input  1 each  master requests a bus beat; held until its beat completes.
REQ-005 m0_lock, m1_lock  input  1 each  master requests to keep ownership after the current beat.
REQ-006 m0_we, m1_we  input  2 each  write control, forwarded unchanged to RAM; 2'b00 = read.
REQ-007 m0_addr, m1_addr, m0_wdata, m1_wdata  input  32 each  beat address and write data.
REQ-008 m0_gnt, m1_gnt  output  1 each  master owns the RAM port this cycle.
REQ-009 m0_rdata, m1_rdata  output  32 each  registered read data.
REQ-010 m0_rvalid, m1_rvalid  output  1 each  one-cycle pulse; rdata is valid.
REQ-011 ram_we  output  2  RAM write control; ram_addr, ram_wdata  output  32 each; ram_rdata  input  32, combinational RAM read data.

Function
REQ-012 FSM states IDLE, OWN0, OWN1; mx_gnt = (state == OWNx), decoded from registered state only.
REQ-013 A beat completes in any cycle where mx_gnt && mx_req; RAM port is then driven by mx_we/mx_addr/mx_wdata.
REQ-014 In IDLE, or in OWNx with mx_req low: ram_we = 2'b00, ram_addr = 0, ram_wdata = 0; no beat.
REQ-015 IDLE: exactly one req -> that master's OWN next cycle; both -> master not in last_owner; none -> stay IDLE.
REQ-016 OWNx after a beat: stay if mx_lock && mx_req, unless beat_cnt == MAX_BURST-1 and the other req is high, then switch.
REQ-017 OWNx otherwise: other req high -> other OWN; else mx_req high -> stay OWNx; else IDLE.
REQ-018 OWNx with mx_req low (no beat): same rule as REQ-017, with lock ignored.
REQ-019 beat_cnt: 3-bit minimum, width clog2(MAX_BURST); increments per beat while owner unchanged; clears on owner change or IDLE; at MAX_BURST-1 with no competing request it wraps to 0 and ownership continues.
REQ-020 last_owner updates to x on every beat by mx.
REQ-021 Read beat (we == 2'b00): ram_rdata captured into mx_rdata at that edge; mx_rvalid high for the following cycle only.
REQ-022 Write beat: no rvalid; mx_rdata holds its previous value.
REQ-023 Latency: req high in cycle N while IDLE -> gnt in N+1 -> rvalid in N+2; back-to-back beats by the owner: one beat per cycle.
REQ-024 gnt outputs are never both high; the RAM port is never driven by a non-owner.

Reset
REQ-025 On reset low, asynchronously: state = IDLE, gnt = 0, rvalid = 0, rdata = 0, beat_cnt = 0, last_owner = M1, so M0 wins the first tie.
REQ-026 Reset mid-beat aborts the beat; no rvalid is produced for it after release.

Structure
REQ-027 Shared package holds the owner enum (M0, M1), the FSM state enum, and the WE_READ = 2'b00 constant.
REQ-028 Single module with no sub-modules; the arbitration next-state logic is one combinational block.

Verification
REQ-029 Reset release, m0_req=1 read at addr 0x10 (RAM holds 0xDEADBEEF) -> m0_gnt in cycle 1, m0_rvalid in cycle 2, m0_rdata = 0xDEADBEEF.
REQ-030 From IDLE, both req with no lock -> grants alternate M0, M1, M0, M1 every cycle.
REQ-031 MAX_BURST=8, m0 locked with req held, m1_req held -> exactly 8 m0 beats, then m1_gnt.
REQ-032 m0 locked alone for 20 beats -> m0_gnt continuous, beat_cnt wraps, no gap.
REQ-033 m1 write we=2'b11, addr 0x20, data 0x12345678 -> ram_we=2'b11 and the data appear during m1_gnt; m1_rvalid stays 0.
REQ-034 Assert reset while OWN1 during a read beat -> all gnt/rvalid 0 immediately; after release, simultaneous requests -> M0 granted first.
